// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one ALU datapath between
//            two requesters. One operation is in flight at a time: accept,
//            wait LAT cycles for the ALU, capture the result and hold it on
//            a valid/ready response channel tagged with the requester id.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_valid/reqN_ready          request handshake for requester N (0/1)
//   reqN_opcode, reqN_a, reqN_b    operation and operands of requester N
//   alu_opcode, alu_a, alu_b       registered operation driven to the ALU
//   alu_out                        ALU result (sampled LAT cycles after load)
//   rsp_valid/rsp_ready            response handshake
//   rsp_id, rsp_data               requester tag and captured result
//   busy                           high whenever an operation is in flight
// ============================================================================
module alu_share_arbiter #(
    parameter int WIDTH = 4,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam logic [3:0] C_LAT = 4'(LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic             w_gnt;   // requester that would be granted in IDLE
    logic             w_idle;
    logic             w_take;

    // Single requester wins outright; on contention the one not served
    // last time wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_gnt = ~last_q;
        end else begin
            w_gnt = req1_valid;
        end
    end

    assign w_idle     = (state_q == S_IDLE);
    assign req0_ready = w_idle && req0_valid && !w_gnt;
    assign req1_ready = w_idle && req1_valid &&  w_gnt;
    assign w_take     = req0_ready || req1_ready;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (w_take) begin
                    opcode_d = w_gnt ? req1_opcode : req0_opcode;
                    a_d      = w_gnt ? req1_a      : req0_a;
                    b_d      = w_gnt ? req1_b      : req0_b;
                    rsp_id_d = w_gnt;
                    last_d   = w_gnt;
                    cnt_d    = C_LAT;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                // cnt==1 marks the edge exactly LAT cycles after the load.
                if (cnt_q == 4'd1) begin
                    rsp_data_d  = alu_out;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            cnt_q       <= 4'd0;
            opcode_q    <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign alu_opcode = opcode_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = !w_idle;

endmodule
`default_nettype wire
